// File: rtl/gpa_fhdo_pkg.sv
// Shared definitions for the GPA-FHDO SPI master: command codes, frame
// lengths, command-word field positions and the transaction FSM states.
package gpa_fhdo_pkg;

   localparam logic [4:0] CMD_DAC  = 5'b00000;
   localparam logic [4:0] CMD_ADC  = 5'b01000;

   localparam int DAC_BITS = 24;
   localparam int ADC_BITS = 32;

   // Command word layout: [31:27] command, [26:25] channel, [24] flag, [23:0] payload.
   localparam int CMD_MSB     = 31;
   localparam int CMD_LSB     = 27;
   localparam int PAYLOAD_MSB = 23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GUARD = 2'd2
   } state_t;

   function automatic logic is_known_cmd(input logic [4:0] code);
      return (code == CMD_DAC) || (code == CMD_ADC);
   endfunction

endpackage

// File: rtl/gpa_fhdo_iface_if.sv
// Command/status and SPI pin bundle of the GPA-FHDO SPI master.
// The slave modport is the view of the SPI master block itself.
interface gpa_fhdo_iface_if;

   logic [31:0] data_i;
   logic        valid_i;
   logic [5:0]  spi_clk_div_i;
   logic        fhd_sdi_i;
   logic        busy_o;
   logic        fhd_sdo_o;
   logic        fhd_clk_o;
   logic        fhd_csn_o;
   logic [15:0] adc_value_o;

   modport master (
      output data_i, valid_i, spi_clk_div_i, fhd_sdi_i,
      input  busy_o, fhd_sdo_o, fhd_clk_o, fhd_csn_o, adc_value_o
   );

   modport slave (
      input  data_i, valid_i, spi_clk_div_i, fhd_sdi_i,
      output busy_o, fhd_sdo_o, fhd_clk_o, fhd_csn_o, adc_value_o
   );

endinterface

// File: rtl/gpa_fhdo_spi_tick.sv
// SCLK half-period timer: tick is high on every (div+1)-th cycle and the
// count restarts from zero whenever clear is asserted.
module gpa_fhdo_spi_tick (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic [5:0] div,
   output logic       tick
);

   logic [5:0] cnt;

   assign tick = (cnt == div);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 6'd1;
      end
   end

endmodule

// File: rtl/gpa_fhdo_iface.sv
// SPI master for the GPA-FHDO board: turns one command word into one
// DAC80504 write frame or one ADS8684 conversion frame on a shared bus.
module gpa_fhdo_iface
   import gpa_fhdo_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   gpa_fhdo_iface_if.slave    bus
);

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        sclk_q, sclk_d;
   logic        csn_q, csn_d;
   logic        sdo_q, sdo_d;
   logic [31:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [4:0]  last_bit_q, last_bit_d;
   logic        is_adc_q, is_adc_d;
   logic [5:0]  div_q, div_d;
   logic [15:0] adc_q, adc_d;
   logic        tick_clear;
   logic        tick;

   logic [4:0]  cmd_code;
   logic [23:0] cmd_payload;

   assign cmd_code    = bus.data_i[CMD_MSB:CMD_LSB];
   assign cmd_payload = bus.data_i[PAYLOAD_MSB:0];

   gpa_fhdo_spi_tick u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .div   (div_q),
      .tick  (tick)
   );

   // NOTE: every *_d defaults to its register value first, so no path through this block infers a latch.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      sclk_d     = sclk_q;
      csn_d      = csn_q;
      sdo_d      = sdo_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_cnt_d  = bit_cnt_q;
      last_bit_d = last_bit_q;
      is_adc_d   = is_adc_q;
      div_d      = div_q;
      adc_d      = adc_q;
      tick_clear = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.valid_i && is_known_cmd(cmd_code)) begin
               state_d    = SHIFT;
               tick_clear = 1'b1;
               busy_d     = 1'b1;
               csn_d      = 1'b0;
               sclk_d     = 1'b1;
               div_d      = bus.spi_clk_div_i;
               bit_cnt_d  = '0;
               if (cmd_code == CMD_ADC) begin
                  is_adc_d   = 1'b1;
                  last_bit_d = 5'(ADC_BITS - 1);
                  tx_d       = {cmd_payload[15:0], 16'h0000};
               end else begin
                  is_adc_d   = 1'b0;
                  last_bit_d = 5'(DAC_BITS - 1);
                  tx_d       = {cmd_payload, 8'h00};
               end
               sdo_d = tx_d[31];
            end
         end

         SHIFT: begin
            if (tick) begin
               if (sclk_q) begin
                  // Falling SCLK: the slave samples SDO, the master samples SDI.
                  sclk_d = 1'b0;
                  rx_d   = {rx_q[14:0], bus.fhd_sdi_i};
               end else if (bit_cnt_q == last_bit_q) begin
                  state_d = GUARD;
                  csn_d   = 1'b1;
                  sdo_d   = 1'b0;
                  if (is_adc_q) begin
                     adc_d = rx_q;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  tx_d      = {tx_q[30:0], 1'b0};
                  sdo_d     = tx_q[30];
                  sclk_d    = 1'b1;
               end
            end
         end

         GUARD: begin
            if (tick) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         csn_q      <= 1'b1;
         sdo_q      <= 1'b0;
         tx_q       <= '0;
         rx_q       <= '0;
         bit_cnt_q  <= '0;
         last_bit_q <= '0;
         is_adc_q   <= 1'b0;
         div_q      <= '0;
         adc_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         csn_q      <= csn_d;
         sdo_q      <= sdo_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_cnt_q  <= bit_cnt_d;
         last_bit_q <= last_bit_d;
         is_adc_q   <= is_adc_d;
         div_q      <= div_d;
         adc_q      <= adc_d;
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.fhd_clk_o   = sclk_q;
   assign bus.fhd_csn_o   = csn_q;
   assign bus.fhd_sdo_o   = sdo_q;
   assign bus.adc_value_o = adc_q;

endmodule

// File: tb/tb_gpa_fhdo_iface.sv
// Bench for gpa_fhdo_iface: DAC80504/ADS8684 bus models, a vector table,
// hand-written multi-cycle sequences and randomised frames.
module tb_gpa_fhdo_iface;

   localparam logic [4:0] C_DAC = 5'b00000;
   localparam logic [4:0] C_ADC = 5'b01000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gpa_fhdo_iface_if bus ();

   gpa_fhdo_iface dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus models: the ADS8684 drives SDI after each rising SCLK, the
   // DAC80504 shifts SDO on falling SCLK and commits on CSn rising.
   logic        adc_sdo = 1'b0;
   logic [15:0] adc_ret = 16'h0000;
   logic [31:0] mon_sh = 32'h0;
   int          mon_bits = 0;
   int          rises = 0;
   int          last_bits = 0;
   int          last_rises = 0;
   int          frame_cnt = 0;
   logic [31:0] words[$];
   logic [15:0] dac_reg [4] = '{default: 16'h0000};

   assign bus.fhd_sdi_i = adc_sdo;

   always @(posedge bus.fhd_clk_o or negedge bus.fhd_clk_o or posedge bus.fhd_csn_o) begin
      if (bus.fhd_csn_o === 1'b1) begin
         frame_cnt++;
         words.push_back(mon_sh);
         last_bits  = mon_bits;
         last_rises = rises;
         if (mon_bits == 24) dac_reg[mon_sh[17:16]] = mon_sh[15:0];
         mon_sh   = 32'h0;
         mon_bits = 0;
         rises    = 0;
         adc_sdo  = 1'b0;
      end else if (bus.fhd_clk_o === 1'b1) begin
         adc_sdo = (rises >= 16 && rises < 32) ? adc_ret[31 - rises] : 1'b0;
         rises++;
      end else if (bus.fhd_clk_o === 1'b0) begin
         mon_sh = {mon_sh[30:0], bus.fhd_sdo_o};
         mon_bits++;
      end
   end

   // Issues one command and follows it until busy_o drops, checking it
   // against expectations computed by the caller.
   task automatic do_frame(input string tag, input logic [4:0] cmd, input logic [23:0] payload,
                           input logic [5:0] d, input logic [15:0] ret, input int exp_busy,
                           input int exp_bits, input logic [31:0] exp_word, input logic [15:0] exp_adc);
      int   busy_n, csn_n, f0, guard;
      logic prev_csn, exp_msb;
      adc_ret = ret;
      f0 = frame_cnt;
      @(negedge clk);
      bus.data_i        = {cmd, 2'($urandom), 1'($urandom), payload};
      bus.spi_clk_div_i = d;
      bus.valid_i       = 1'b1;
      @(negedge clk);
      bus.valid_i       = 1'b0;
      bus.spi_clk_div_i = 6'($urandom);
      bus.data_i        = $urandom;
      exp_msb = (exp_bits == 0) ? 1'b0 : exp_word[exp_bits - 1];
      check({tag, " start"}, 32'({bus.busy_o, bus.fhd_csn_o, bus.fhd_clk_o, bus.fhd_sdo_o}),
            32'((exp_bits == 0) ? 4'b0100 : {3'b101, exp_msb}));
      busy_n = 0; csn_n = 0; guard = 0;
      prev_csn = bus.fhd_csn_o;
      while (bus.busy_o && guard < 6000) begin
         busy_n++;
         if (!bus.fhd_csn_o) csn_n++;
         if (bus.fhd_csn_o && !prev_csn && exp_bits == 32)
            check({tag, " adc_at_csn_rise"}, 32'(bus.adc_value_o), 32'(exp_adc));
         prev_csn = bus.fhd_csn_o;
         @(negedge clk);
         guard++;
      end
      check({tag, " busy_cycles"}, busy_n, exp_busy);
      check({tag, " csn_low_cycles"}, csn_n, exp_bits * 2 * (int'(d) + 1));
      check({tag, " frames"}, frame_cnt - f0, (exp_bits != 0) ? 1 : 0);
      if (exp_bits != 0) begin
         check({tag, " frame_bits"}, last_bits, exp_bits);
         check({tag, " sclk_pulses"}, last_rises, exp_bits);
         check({tag, " sdo_word"}, words[words.size() - 1], exp_word);
      end
      if (exp_bits == 24)
         check({tag, " dac_reg"}, 32'(dac_reg[payload[17:16]]), 32'(payload[15:0]));
      check({tag, " adc_value"}, 32'(bus.adc_value_o), 32'(exp_adc));
   endtask

   typedef struct {
      logic [4:0]  cmd;
      logic [23:0] payload;
      logic [5:0]  d;
      logic [15:0] ret;
      int          exp_busy;
      int          exp_bits;
      logic [31:0] exp_word;
      logic [15:0] exp_adc;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          f0, w0, guard, g, d_b2b;
      logic [4:0]  rcmd;
      logic [23:0] rpay;
      logic [5:0]  rd;
      logic [15:0] rret, exp_adc_m;
      int          nb;

      vecs[0] = '{C_DAC,    24'h000001, 6'd32, 16'h0000, 1617, 24, 32'h0000_0001, 16'h0000};
      vecs[1] = '{C_ADC,    24'h00C000, 6'd32, 16'h1234, 2145, 32, 32'hC000_0000, 16'h1234};
      vecs[2] = '{C_DAC,    24'h03A5A5, 6'd0,  16'h0000, 49,   24, 32'h0003_A5A5, 16'h1234};
      vecs[3] = '{C_ADC,    24'h7FD400, 6'd0,  16'hBEEF, 65,   32, 32'hD400_0000, 16'hBEEF};
      vecs[4] = '{5'b11111, 24'h00C000, 6'd3,  16'h5555, 0,    0,  32'h0,         16'hBEEF};
      vecs[5] = '{5'b01001, 24'h00C000, 6'd1,  16'h5555, 0,    0,  32'h0,         16'hBEEF};

      bus.data_i = '0; bus.valid_i = 1'b0; bus.spi_clk_div_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset outputs", 32'({bus.busy_o, bus.fhd_csn_o, bus.fhd_clk_o, bus.fhd_sdo_o}), 32'(4'b0100));
      check("reset adc_value", 32'(bus.adc_value_o), 32'h0);

      for (int i = 0; i < 6; i++)
         do_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].payload, vecs[i].d, vecs[i].ret,
                  vecs[i].exp_busy, vecs[i].exp_bits, vecs[i].exp_word, vecs[i].exp_adc);

      // valid_i held high for 2000 cycles: one in-flight frame, one retrigger.
      f0 = frame_cnt; w0 = words.size();
      @(negedge clk);
      bus.data_i = {C_DAC, 3'b000, 24'h011111}; bus.spi_clk_div_i = 6'd32; bus.valid_i = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (i == 100) bus.data_i = {C_DAC, 3'b000, 24'h022222};
      end
      bus.valid_i = 1'b0;
      guard = 0;
      while (bus.busy_o && guard < 4000) begin @(negedge clk); guard++; end
      check("held_valid idle_reached", 32'(bus.busy_o), 32'h0);
      check("held_valid frames", frame_cnt - f0, 2);
      check("held_valid word0", (words.size() > w0) ? words[w0] : 32'hFFFF_FFFF, 32'h0001_1111);
      check("held_valid word1", (words.size() > w0 + 1) ? words[w0 + 1] : 32'hFFFF_FFFF, 32'h0002_2222);

      // Back-to-back DAC writes, each issued on the first cycle busy_o is low.
      d_b2b = 3;
      @(negedge clk);
      bus.data_i = {C_DAC, 3'b000, 6'd0, 2'd0, 16'h000A}; bus.spi_clk_div_i = 6'(d_b2b); bus.valid_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
         guard = 0;
         while (!bus.fhd_csn_o && guard < 1000) begin @(negedge clk); guard++; end
         g = 0;
         while (bus.fhd_csn_o && bus.busy_o && g < 1000) begin @(negedge clk); g++; end
         check($sformatf("b2b guard ch%0d", ch), g, d_b2b + 1);
         if (ch < 3) begin
            bus.data_i  = {C_DAC, 3'b000, 6'd0, 2'(ch + 1), 16'(16'hA + ch + 1)};
            bus.valid_i = 1'b1;
            @(negedge clk);
            bus.valid_i = 1'b0;
            check($sformatf("b2b restart ch%0d", ch + 1), 32'({bus.busy_o, bus.fhd_csn_o}), 32'(2'b10));
         end
      end
      for (int ch = 0; ch < 4; ch++)
         check($sformatf("b2b dac_reg ch%0d", ch), 32'(dac_reg[ch]), 32'(16'hA + ch));

      // Reset in the middle of an ADC frame.
      adc_ret = 16'h0F0F;
      @(negedge clk);
      bus.data_i = {C_ADC, 3'b000, 24'h00C000}; bus.spi_clk_div_i = 6'd4; bus.valid_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abort outputs", 32'({bus.busy_o, bus.fhd_csn_o, bus.fhd_clk_o, bus.fhd_sdo_o}), 32'(4'b0100));
      check("rst_abort adc_value", 32'(bus.adc_value_o), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Random frames against the reference expectations.
      exp_adc_m = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 2))
            0: rcmd = C_DAC;
            1: rcmd = C_ADC;
            default: begin
               rcmd = 5'($urandom);
               while (rcmd == C_DAC || rcmd == C_ADC) rcmd = 5'($urandom);
            end
         endcase
         rpay = 24'($urandom);
         rd   = 6'($urandom_range(0, 5));
         rret = 16'($urandom);
         nb   = (rcmd == C_DAC) ? 24 : (rcmd == C_ADC) ? 32 : 0;
         if (rcmd == C_ADC) exp_adc_m = rret;
         do_frame($sformatf("rand%0d", i), rcmd, rpay, rd, rret,
                  (nb == 0) ? 0 : (2 * nb + 1) * (int'(rd) + 1), nb,
                  (rcmd == C_ADC) ? {rpay[15:0], 16'h0000} : {8'h00, rpay},
                  exp_adc_m);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
